// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the debounce_edge block:
//     state_t                - debouncer FSM state encoding
//     DEFAULT_STABLE_CYCLES  - default stability run length
//     is_high_state()        - level implied by an FSM state
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE,
    LOW_CHECK,
    HIGH_STABLE,
    HIGH_CHECK
  } state_t;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  function automatic logic is_high_state(input state_t st);
    return (st == HIGH_STABLE) || (st == HIGH_CHECK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk   - sampling clock
//     reset - asynchronous active-high reset, clears both flops to 0
//     d     - asynchronous input bit
//     q     - synchronized output (two clk edges of delay)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  always_comb q = sync_q;

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge
//   Debounces a single bit: the output level follows the input only after
//   the input has differed from the current level for STABLE_CYCLES
//   consecutive sampled cycles. A one-cycle strobe accompanies each change.
//   Optional macro DEBOUNCE_EDGE_SYNC_EN inserts a two-flop synchronizer
//   (sync_2ff) in front of the FSM, adding two cycles to every latency.
//   Parameters:
//     STABLE_CYCLES - required run of differing samples (1..65535)
//     CNT_W         - stability counter width, must hold STABLE_CYCLES-1
//   Ports:
//     clk        - clock, all state changes on its rising edge
//     reset      - asynchronous active-high reset
//     d_in       - raw input bit (upstream d_ff Q output)
//     level_out  - debounced level, registered
//     rise_pulse - one-cycle strobe when level_out goes 0->1, registered
//     fall_pulse - one-cycle strobe when level_out goes 1->0, registered
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             SINGLE   = (STABLE_CYCLES == 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             s;

`ifdef DEBOUNCE_EDGE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (s)
  );
`else
  always_comb s = d_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt counts differing samples seen so far in the current *_CHECK run;
  // the sample that makes it reach STABLE_CYCLES flips the level directly,
  // so cnt itself never exceeds STABLE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      LOW_STABLE: begin
        cnt_d = '0;
        if (s) begin
          if (SINGLE) begin
            state_d = HIGH_STABLE;
            rise_d  = 1'b1;
          end else begin
            state_d = LOW_CHECK;
            cnt_d   = CNT_ONE;
          end
        end
      end

      LOW_CHECK: begin
        if (!s) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HIGH_STABLE: begin
        cnt_d = '0;
        if (!s) begin
          if (SINGLE) begin
            state_d = LOW_STABLE;
            fall_d  = 1'b1;
          end else begin
            state_d = HIGH_CHECK;
            cnt_d   = CNT_ONE;
          end
        end
      end

      HIGH_CHECK: begin
        if (s) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase

    level_d = is_high_state(state_d);
  end

  always_comb begin
    level_out  = level_q;
    rise_pulse = rise_q;
    fall_pulse = fall_q;
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge
//   Scoreboarded bench for debounce_edge (STABLE_CYCLES=4, 20 ns clock).
//   A reference model keeps the history of samples since reset and flips
//   its level whenever the last STABLE_CYCLES samples all differ from it;
//   expected outputs are queued per rising edge and checked on the
//   following falling edge by an independent monitor.
module tb_debounce_edge;

  localparam int unsigned SC = 4;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_in = 1'b1;
  logic level_out, rise_pulse, fall_pulse;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_no = 0;

  exp_t exp_q[$];

  // reference model state
  bit   hist[$];
  bit   m_lvl = 1'b0;
  bit   p1 = 1'b0;
  bit   p2 = 1'b0;

  debounce_edge #(
    .STABLE_CYCLES (SC),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #10 clk = ~clk;

  function automatic exp_t model_step(input bit rst, input bit din);
    exp_t e;
    bit   s;
    bit   all_diff;
    e = '0;
    if (rst) begin
      hist.delete();
      m_lvl = 1'b0;
      p1 = 1'b0;
      p2 = 1'b0;
    end else begin
`ifdef DEBOUNCE_EDGE_SYNC_EN
      s  = p2;
      p2 = p1;
      p1 = din;
`else
      s  = din;
`endif
      hist.push_back(s);
      if (hist.size() > SC) void'(hist.pop_front());
      all_diff = (hist.size() == SC);
      foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl  = ~m_lvl;
        e.rise = m_lvl;
        e.fall = ~m_lvl;
      end
    end
    e.lvl = m_lvl;
    return e;
  endfunction

  // stimulus-side model: one expectation per rising edge
  initial begin
    forever begin
      @(posedge clk);
      exp_q.push_back(model_step(reset, d_in));
    end
  end

  // monitor: outputs are presented every cycle; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        edge_no++;
        n_cmp++;
        if ({level_out, rise_pulse, fall_pulse} !== {e.lvl, e.rise, e.fall}) begin
          n_bad++;
          $display("FAIL outputs edge %0d: level/rise/fall got %b%b%b expected %b%b%b",
                   edge_no, level_out, rise_pulse, fall_pulse, e.lvl, e.rise, e.fall);
        end
      end
    end
  end

  task automatic drive(input logic b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      d_in = b;
    end
  endtask

  // reset pulse of 15 ns that straddles one rising edge
  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({level_out, rise_pulse, fall_pulse} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset: level/rise/fall got %b%b%b expected 000",
               level_out, rise_pulse, fall_pulse);
    end
    #14 reset = 1'b0;
  endtask

  initial begin
    logic v;
    #1 reset = 1'b1;
    d_in = 1'b1;
    repeat (5) @(negedge clk);
    #1 reset = 1'b0;

    // d_in held high through and after reset: rise after SC samples
    drive(1'b1, 8);
    // fall after SC low samples, then toggling must not move the level
    drive(1'b0, 6);
    for (int unsigned i = 0; i < 20; i++) drive(i[0] ? 1'b0 : 1'b1, 1);
    // bounce inside the check window, then a clean run
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 7);
    drive(1'b0, 6);
    // partial run discarded by reset
    drive(1'b1, 2);
    reset_pulse();
    drive(1'b1, 7);
    drive(1'b0, 6);

    // randomized runs with occasional reset pulses
    v = 1'b0;
    for (int unsigned r = 0; r < 120; r++) begin
      v = ~v;
      drive(v, $urandom_range(1, 7));
      if ($urandom_range(0, 11) == 0) reset_pulse();
    end
    for (int unsigned i = 0; i < 60; i++) drive(1'($urandom_range(0, 1)), 1);

    drive(d_in, 3);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive sampled cycles the input must differ from the current level before the level changes; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stability counter width; CNT_W SHALL hold STABLE_CYCLES-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port d_in  input  1  raw bit from the upstream d_ff stage Q output.
REQ-006 SHALL have port level_out  output  1  debounced level, registered.
REQ-007 SHALL have port rise_pulse  output  1  one-cycle strobe when level_out goes 0->1, registered.
REQ-008 SHALL have port fall_pulse  output  1  one-cycle strobe when level_out goes 1->0, registered.

Function
REQ-009 SHALL use FSM states LOW_STABLE, LOW_CHECK, HIGH_STABLE, HIGH_CHECK; level_out is 0 in LOW_*, 1 in HIGH_*.
REQ-010 In a *_STABLE state, a sample (s) equal to level_out SHALL keep the state and cnt=0.
REQ-011 In a *_STABLE state, s != level_out SHALL go to the matching *_CHECK state with cnt=1; if STABLE_CYCLES=1, it SHALL go directly to the opposite *_STABLE state.
REQ-012 In a *_CHECK state, s equal to level_out (bounce) SHALL return to the matching *_STABLE state with cnt=0 and no pulse.
REQ-013 In a *_CHECK state, s != level_out with cnt=STABLE_CYCLES-1 SHALL go to the opposite *_STABLE state and clear cnt; otherwise cnt SHALL increment.
REQ-014 level_out SHALL change on the rising edge that samples the STABLE_CYCLES-th consecutive differing value of s.
REQ-015 rise_pulse/fall_pulse SHALL be high for exactly the one cycle in which level_out first shows its new value; they SHALL never be high together.
REQ-016 s SHALL be d_in directly; latency from the first stable d_in sample edge to level_out change SHALL be STABLE_CYCLES-1 further edges.
REQ-017 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 An input toggling every cycle SHALL never change level_out for STABLE_CYCLES>=2.

Reset
REQ-019 While reset=1, state SHALL be LOW_STABLE, cnt=0, level_out=0, rise_pulse=0, fall_pulse=0, regardless of clk or d_in.
REQ-020 Reset asserted during a *_CHECK state SHALL discard the partial count; after release a full STABLE_CYCLES stable run SHALL be required.
REQ-021 The first edge after reset release SHALL be treated as a normal sample from LOW_STABLE; a d_in held at 1 through reset SHALL produce a rise_pulse after STABLE_CYCLES samples.

Configuration
REQ-022 With macro DEBOUNCE_EDGE_SYNC_EN defined, s SHALL be d_in after a two-flop synchronizer, both flops reset to 0, adding exactly 2 cycles to all latencies.
REQ-023 Without DEBOUNCE_EDGE_SYNC_EN, no synchronizer SHALL exist and REQ-016 latency applies.

Structure
REQ-024 Package debounce_pkg SHALL hold the FSM state enum and the default STABLE_CYCLES constant.
REQ-025 The synchronizer SHALL be sub-module sync_2ff (ports clk, reset, d, q), instantiated only under DEBOUNCE_EDGE_SYNC_EN.

Verification (STABLE_CYCLES=4, clk period 20 ns, macro off unless stated)
REQ-026 reset=1 for 100 ns with d_in=1 -> level_out=0, both pulses 0 throughout.
REQ-027 d_in 0->1 held from edge k -> level_out=1 and rise_pulse=1 after edge k+3, rise_pulse=0 after edge k+4.
REQ-028 d_in=1 for 3 edges, 0 for 1 edge, then 1 held -> no rise during the bounce; rise after the 4th edge of the final run.
REQ-029 From level_out=1, d_in=0 held 4 edges -> fall_pulse one cycle, level_out=0; d_in toggling every edge for 20 edges -> no change.
REQ-030 d_in=1 for 2 edges, reset pulsed 15 ns, d_in still 1 -> level_out 0 immediately; rise only after 4 edges following release.
REQ-031 DEBOUNCE_EDGE_SYNC_EN defined, REQ-027 stimulus -> level_out rises after edge k+5.
